// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg: shared types and constants for the instruction loader     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_SHIFT     = 2;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_loader_if: byte stream in, instruction memory write port out|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface instr_mem_loader_if #(
  parameter int BUS = 32
);
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic           byte_ready;
  logic           mem_we;
  logic [BUS-1:0] mem_addr;
  logic [BUS-1:0] mem_wdata;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_assembler: packs bytes little-endian into a 32-bit word          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module byte_assembler
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        load,
  input  logic [7:0]                  byte_data,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        last_byte
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (load) begin
      // Lane chosen by arrival order gives little-endian packing
      word_d[8*byte_cnt_q +: 8] = byte_data;
      byte_cnt_d                = byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word      = word_q;
  assign last_byte = (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_loader: streams a program into instruction memory while     |
// | holding the CPU in reset. Rev 1.0                                     |
// +----------------------------------------------------------------------+
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BUS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  instr_mem_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               word_idx_q, word_idx_d;
  logic [ADDR_W:0]                 num_words_q, num_words_d;
  logic [8*BYTES_PER_WORD-1:0]     asm_word;
  logic                            asm_last;
  logic                            hs;
  logic                            load_start;
  logic                            last_word;
  logic [BUS-1:0]                  addr_ext;

  assign hs         = bus.byte_valid & (state_q == S_RECV);
  assign load_start = start & (state_q == S_IDLE);
  // Computed one bit wider so a full 2^ADDR_W load ends at the top index
  assign last_word  = ({1'b0, word_idx_q} == (num_words_q - 1'b1));

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .load      (hs),
    .byte_data (bus.byte_data),
    .word      (asm_word),
    .last_byte (asm_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      num_words_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      num_words_q <= num_words_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    num_words_d = num_words_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_words_d = num_words;
          word_idx_d  = '0;
          state_d     = (num_words == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (hs && asm_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = S_RECV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, never the inputs
  always_comb begin
    addr_ext      = BUS'(word_idx_q);
    bus.byte_ready = (state_q == S_RECV);
    bus.mem_we     = (state_q == S_WRITE);
    bus.mem_addr   = addr_ext << ADDR_SHIFT;
    bus.mem_wdata  = BUS'(asm_word);
    cpu_hold       = (state_q != S_IDLE);
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_mem_loader: scoreboard bench with random byte streams        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_instr_mem_loader;
  localparam int ADDR_W = 4;
  localparam int BUS    = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [ADDR_W:0] num_words = '0;
  logic            cpu_hold, busy, done;

  int   total = 0;
  int   bad = 0;
  int   writes_seen = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;
  wr_t  mon_e;
  wr_t  exp_q[$];
  logic [7:0] stim_q[$];

  instr_mem_loader_if #(.BUS(BUS)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .BUS(BUS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes memory
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        writes_seen++;
        check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, mon_e.addr);
          check("wr_data", bus.mem_wdata, mon_e.data);
        end
      end
      if (done) begin
        done_seen++;
        check("hold_at_done", 32'(cpu_hold), 32'd1);
      end
      if (prev_done) check("hold_after_done", 32'(cpu_hold), 32'd0);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Reference model: word i is bytes 4i..4i+3 little-endian at byte address 4i
  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = 32'(4 * i);
      e.data = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_random(input int n_bytes);
    stim_q.delete();
    for (int i = 0; i < n_bytes; i++) stim_q.push_back(8'($urandom));
  endtask

  // Negative bubble_pct alternates valid every cycle
  task automatic send_stream(input int n_bytes, input int bubble_pct);
    int   idx;
    int   budget;
    logic hs;
    idx    = 0;
    budget = 20 * n_bytes + 50;
    while (idx < n_bytes && budget > 0) begin
      bus.byte_valid = (bubble_pct < 0) ? logic'(budget % 2)
                                        : (int'($urandom_range(99)) >= bubble_pct);
      bus.byte_data  = stim_q[idx];
      hs = bus.byte_valid & bus.byte_ready;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      budget--;
    end
    bus.byte_valid = 1'b0;
    if (idx < n_bytes) check("stream_timeout", 32'(idx), 32'(n_bytes));
  endtask

  task automatic run_load(input int n, input int bubble_pct);
    int w0, d0, t;
    w0 = writes_seen;
    d0 = done_seen;
    push_expected(n);
    num_words = (ADDR_W + 1)'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) check("zero_done_next_cycle", 32'(done), 32'd1);
    send_stream(4 * n, bubble_pct);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("write_count", 32'(writes_seen - w0), 32'(n));
    check("done_count", 32'(done_seen - d0), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #12;
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2, 0);
    run_load(2, -1);

    stim_q.delete();
    run_load(0, 0);

    stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    fork
      run_load(2, 0);
      begin
        repeat (3) @(negedge clk);
        num_words = 5'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Abort after six bytes: only the first word may have been written
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_expected(1);
    num_words = 5'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_stream(6, 0);
    #1 reset = 1'b1;
    #1;
    check("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we", 32'(bus.mem_we), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_mem_wdata", bus.mem_wdata, 32'd0);
    check("abort_scoreboard", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    stim_q = '{8'h01, 8'h00, 8'hA0, 8'hE3};
    run_load(1, 0);

    fill_random(4 * 16);
    run_load(16, 20);

    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(16));
      fill_random(4 * n);
      run_load(n, int'($urandom_range(60)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
